// File: rtl/mempool_dma_sink_pkg.sv
// mempool_dma_sink_pkg: shared state encoding, burst record and beat-size helper for the DMA burst sink
package mempool_dma_sink_pkg;
  localparam int unsigned SinkAddrWidth = 32;
  localparam int unsigned SinkNumBytesWidth = 32;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ_REQ,
    ST_READ_WAIT,
    ST_WRITE_REQ,
    ST_RETIRE
  } sink_state_e;
  typedef struct packed {
    logic [SinkAddrWidth-1:0]     src;
    logic [SinkAddrWidth-1:0]     dst;
    logic [SinkNumBytesWidth-1:0] num_bytes;
  } sink_burst_t;
  function automatic int unsigned bytes_per_beat(input int unsigned data_width);
    return data_width / 8;
  endfunction
endpackage

// File: rtl/mempool_dma_sink_fifo.sv
// mempool_dma_sink_fifo: burst request queue with registered occupancy and a look-ahead empty flag
module mempool_dma_sink_fifo
  import mempool_dma_sink_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push,
  input  logic        pop,
  input  sink_burst_t push_data,
  output logic        full,
  output logic        empty,
  output logic        empty_next,
  output sink_burst_t head
);
  localparam int unsigned PtrW = Depth > 1 ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  sink_burst_t slots [Depth];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [CntW-1:0] count, count_d;
  logic do_push, do_pop;
  function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
    return p == PtrW'(Depth - 1) ? '0 : p + PtrW'(1);
  endfunction
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign count_d = count + CntW'(do_push) - CntW'(do_pop);
  assign full = count == CntW'(Depth);
  assign empty = count == '0;
  assign empty_next = count_d == '0;
  assign head = slots[rd_ptr];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? inc(wr_ptr) : wr_ptr;
      rd_ptr <= do_pop ? inc(rd_ptr) : rd_ptr;
      count <= count_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) slots[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/mempool_dma_burst_sink.sv
// mempool_dma_burst_sink: queues 1D DMA bursts and copies them word by word; MEMPOOL_DMA_SINK_STATS_EN adds beat/busy counters
module mempool_dma_burst_sink
  import mempool_dma_sink_pkg::*;
#(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned NumBytesWidth = 32,
  parameter int unsigned QueueDepth    = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     burst_valid_i,
  output logic                     burst_ready_o,
  input  logic [AddrWidth-1:0]     burst_src_i,
  input  logic [AddrWidth-1:0]     burst_dst_i,
  input  logic [NumBytesWidth-1:0] burst_num_bytes_i,
  output logic                     trans_complete_o,
  output logic                     backend_idle_o,
  output logic                     error_o,
`ifdef MEMPOOL_DMA_SINK_STATS_EN
  output logic [31:0]              beats_o,
  output logic [31:0]              busy_cycles_o,
`endif
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [AddrWidth-1:0]     mem_addr_o,
  output logic [DataWidth-1:0]     mem_wdata_o,
  output logic [DataWidth/8-1:0]   mem_be_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  input  logic [DataWidth-1:0]     mem_rdata_i
);
  localparam int unsigned Bpb = bytes_per_beat(DataWidth);
  localparam int unsigned Lsb = $clog2(Bpb);
  sink_state_e state_q, state_d;
  sink_burst_t head, in_burst;
  logic full, empty, empty_next, push, pop, misaligned, start;
  logic [AddrWidth-1:0] src_q, dst_q;
  logic [NumBytesWidth-1:0] rem_q;
  logic [DataWidth-1:0] data_q;
  logic err_q, idle_q, wr_gnt;
  assign in_burst = '{src: burst_src_i, dst: burst_dst_i, num_bytes: burst_num_bytes_i};
  assign push = burst_valid_i && !full;
  assign pop = state_q == ST_RETIRE;
  mempool_dma_sink_fifo #(.Depth(QueueDepth)) i_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (push),
    .pop       (pop),
    .push_data (in_burst),
    .full      (full),
    .empty     (empty),
    .empty_next(empty_next),
    .head      (head)
  );
  // zero-length bursts retire before the alignment check, so they never flag an error
  assign misaligned = |{head.src[Lsb-1:0], head.dst[Lsb-1:0], head.num_bytes[Lsb-1:0]};
  assign start = state_q == ST_IDLE && !empty;
  assign wr_gnt = state_q == ST_WRITE_REQ && mem_gnt_i;
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (!empty) state_d = (head.num_bytes == '0 || misaligned) ? ST_RETIRE : ST_READ_REQ;
      ST_READ_REQ:  if (mem_gnt_i) state_d = ST_READ_WAIT;
      ST_READ_WAIT: if (mem_rvalid_i) state_d = ST_WRITE_REQ;
      ST_WRITE_REQ: if (mem_gnt_i) state_d = rem_q == NumBytesWidth'(Bpb) ? ST_RETIRE : ST_READ_REQ;
      default:      state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      src_q <= '0;
      dst_q <= '0;
      rem_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
      idle_q <= 1'b1;
    end else begin
      state_q <= state_d;
      src_q <= start ? head.src : wr_gnt ? src_q + AddrWidth'(Bpb) : src_q;
      dst_q <= start ? head.dst : wr_gnt ? dst_q + AddrWidth'(Bpb) : dst_q;
      rem_q <= start ? head.num_bytes : wr_gnt ? rem_q - NumBytesWidth'(Bpb) : rem_q;
      data_q <= (state_q == ST_READ_WAIT && mem_rvalid_i) ? mem_rdata_i : data_q;
      err_q <= err_q || (start && head.num_bytes != '0 && misaligned);
      idle_q <= state_d == ST_IDLE && empty_next;
    end
  end
`ifdef MEMPOOL_DMA_SINK_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beats_o <= '0;
      busy_cycles_o <= '0;
    end else begin
      beats_o <= (wr_gnt && beats_o != '1) ? beats_o + 32'd1 : beats_o;
      busy_cycles_o <= (state_q != ST_IDLE && busy_cycles_o != '1) ? busy_cycles_o + 32'd1 : busy_cycles_o;
    end
  end
`endif
  assign burst_ready_o = !full;
  assign trans_complete_o = pop;
  assign backend_idle_o = idle_q;
  assign error_o = err_q;
  assign mem_req_o = state_q == ST_READ_REQ || state_q == ST_WRITE_REQ;
  assign mem_we_o = state_q == ST_WRITE_REQ;
  assign mem_addr_o = state_q == ST_READ_REQ ? src_q : state_q == ST_WRITE_REQ ? dst_q : '0;
  assign mem_wdata_o = mem_we_o ? data_q : '0;
  assign mem_be_o = '1;
endmodule

// File: tb/tb_mempool_dma_burst_sink.sv
// tb_mempool_dma_burst_sink: directed tests of the burst sink against a simple responding memory
module tb_mempool_dma_burst_sink;
  logic clk, rst_i;
  logic burst_valid_i, burst_ready_o;
  logic [31:0] burst_src_i, burst_dst_i, burst_num_bytes_i;
  logic trans_complete_o, backend_idle_o, error_o;
  logic mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0] mem_be_o;
`ifdef MEMPOOL_DMA_SINK_STATS_EN
  logic [31:0] beats_o, busy_cycles_o;
`endif
  int checks = 0, failures = 0;
  int gnt_delay = 0, wait_cnt = 0, completes = 0, req_cycles = 0;
  bit gnt_block = 0, hold_rvalid = 0, rd_pend = 0;
  logic [31:0] rd_addr;
  logic [31:0] log_addr[$], log_wdata[$], exp_addr[$], exp_wdata[$];
  logic log_we[$], exp_we[$];

  mempool_dma_burst_sink dut (
    .clk_i(clk), .rst_i(rst_i),
    .burst_valid_i(burst_valid_i), .burst_ready_o(burst_ready_o),
    .burst_src_i(burst_src_i), .burst_dst_i(burst_dst_i), .burst_num_bytes_i(burst_num_bytes_i),
    .trans_complete_o(trans_complete_o), .backend_idle_o(backend_idle_o), .error_o(error_o),
`ifdef MEMPOOL_DMA_SINK_STATS_EN
    .beats_o(beats_o), .busy_cycles_o(busy_cycles_o),
`endif
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  // memory: grants after gnt_delay waiting cycles, returns read data the cycle after the grant
  initial begin
    mem_gnt_i = 0;
    mem_rvalid_i = 0;
    mem_rdata_i = 0;
    rd_addr = 0;
    forever begin
      @(negedge clk);
      if (trans_complete_o) completes++;
      if (mem_req_o) req_cycles++;
      mem_rvalid_i = 0;
      if (rd_pend && !hold_rvalid) begin
        mem_rvalid_i = 1;
        mem_rdata_i = rd_fn(rd_addr);
        rd_pend = 0;
      end
      mem_gnt_i = 0;
      if (!mem_req_o) wait_cnt = 0;
      else if (!gnt_block) begin
        if (wait_cnt >= gnt_delay) begin
          mem_gnt_i = 1;
          wait_cnt = 0;
          log_addr.push_back(mem_addr_o);
          log_we.push_back(mem_we_o);
          log_wdata.push_back(mem_wdata_o);
          if (!mem_we_o) begin
            rd_pend = 1;
            rd_addr = mem_addr_o;
          end
        end else wait_cnt++;
      end
    end
  end

  task automatic clear_logs();
    log_addr.delete(); log_we.delete(); log_wdata.delete();
    exp_addr.delete(); exp_we.delete(); exp_wdata.delete();
  endtask

  task automatic expect_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
    for (int k = 0; k < int'(n / 4); k++) begin
      exp_addr.push_back(s + 32'(4 * k)); exp_we.push_back(1'b0); exp_wdata.push_back(32'h0);
      exp_addr.push_back(d + 32'(4 * k)); exp_we.push_back(1'b1); exp_wdata.push_back(rd_fn(s + 32'(4 * k)));
    end
  endtask

  task automatic send(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
    int k = 0;
    burst_valid_i = 1; burst_src_i = s; burst_dst_i = d; burst_num_bytes_i = n;
    while (!burst_ready_o && k < 400) begin @(negedge clk); k++; end
    checks++;
    if (!burst_ready_o) begin failures++; $display("FAIL send_ready got=0 exp=1"); end
    @(negedge clk);
    burst_valid_i = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!backend_idle_o && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (!backend_idle_o) begin failures++; $display("FAIL %s idle got=0 exp=1", name); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_i = 1; burst_valid_i = 0; burst_src_i = 0; burst_dst_i = 0; burst_num_bytes_i = 0;
    repeat (3) @(negedge clk);
    rst_i = 0;
    @(negedge clk);
    checks += 5;
    if ({burst_ready_o, trans_complete_o, backend_idle_o, error_o} !== 4'b1010) begin failures++; $display("FAIL reset_status got=%b exp=1010", {burst_ready_o, trans_complete_o, backend_idle_o, error_o}); end
    if ({mem_req_o, mem_we_o} !== 2'b00) begin failures++; $display("FAIL reset_req_we got=%b exp=00", {mem_req_o, mem_we_o}); end
    if (mem_addr_o !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", mem_addr_o); end
    if (mem_wdata_o !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata_o); end
    if (mem_be_o !== 4'hF) begin failures++; $display("FAIL reset_be got=%h exp=f", mem_be_o); end
  endtask

  task automatic test_copy16();
    int c0 = completes;
    clear_logs();
    expect_copy(32'h1000, 32'h2000, 32'd16);
    send(32'h1000, 32'h2000, 32'd16);
    wait_idle("copy16");
    checks++;
    if (log_addr.size() != exp_addr.size()) begin failures++; $display("FAIL copy16_beats got=%0d exp=%0d", log_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
      checks++;
      if (log_we[i] !== exp_we[i] || log_addr[i] !== exp_addr[i] || (exp_we[i] && log_wdata[i] !== exp_wdata[i])) begin
        failures++; $display("FAIL copy16_access%0d got=%b/%h/%h exp=%b/%h/%h", i, log_we[i], log_addr[i], log_wdata[i], exp_we[i], exp_addr[i], exp_wdata[i]);
      end
    end
    checks += 2;
    if (completes - c0 != 1) begin failures++; $display("FAIL copy16_complete got=%0d exp=1", completes - c0); end
    if (error_o !== 1'b0) begin failures++; $display("FAIL copy16_error got=%b exp=0", error_o); end
  endtask

  task automatic test_zero();
    int c0 = completes, r0 = req_cycles;
    send(32'h10, 32'h20, 32'd0);
    checks++;
    if (trans_complete_o !== 1'b0) begin failures++; $display("FAIL zero_early_pulse got=%b exp=0", trans_complete_o); end
    @(negedge clk);
    checks++;
    if (trans_complete_o !== 1'b1) begin failures++; $display("FAIL zero_pulse got=%b exp=1", trans_complete_o); end
    @(negedge clk);
    checks++;
    if (trans_complete_o !== 1'b0) begin failures++; $display("FAIL zero_pulse_end got=%b exp=0", trans_complete_o); end
    wait_idle("zero");
    checks += 3;
    if (completes - c0 != 1) begin failures++; $display("FAIL zero_complete got=%0d exp=1", completes - c0); end
    if (req_cycles != r0) begin failures++; $display("FAIL zero_req got=%0d exp=0", req_cycles - r0); end
    if (error_o !== 1'b0) begin failures++; $display("FAIL zero_error got=%b exp=0", error_o); end
  endtask

  task automatic test_misaligned();
    int c0 = completes, r0 = req_cycles;
    clear_logs();
    send(32'h1002, 32'h3000, 32'd8);
    wait_idle("misaligned");
    checks += 3;
    if (error_o !== 1'b1) begin failures++; $display("FAIL misaligned_error got=%b exp=1", error_o); end
    if (req_cycles != r0) begin failures++; $display("FAIL misaligned_req got=%0d exp=0", req_cycles - r0); end
    if (completes - c0 != 1) begin failures++; $display("FAIL misaligned_complete got=%0d exp=1", completes - c0); end
    expect_copy(32'h1100, 32'h3100, 32'd4);
    send(32'h1100, 32'h3100, 32'd4);
    wait_idle("after_misaligned");
    checks++;
    if (log_addr.size() != exp_addr.size()) begin failures++; $display("FAIL after_misaligned_beats got=%0d exp=%0d", log_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
      checks++;
      if (log_we[i] !== exp_we[i] || log_addr[i] !== exp_addr[i] || (exp_we[i] && log_wdata[i] !== exp_wdata[i])) begin
        failures++; $display("FAIL after_misaligned_access%0d got=%b/%h/%h exp=%b/%h/%h", i, log_we[i], log_addr[i], log_wdata[i], exp_we[i], exp_addr[i], exp_wdata[i]);
      end
    end
    checks++;
    if (error_o !== 1'b1) begin failures++; $display("FAIL error_sticky got=%b exp=1", error_o); end
  endtask

  task automatic test_queue_full();
    int c0 = completes, k = 0;
    clear_logs();
    expect_copy(32'h100, 32'h800, 32'd4);
    expect_copy(32'h200, 32'h900, 32'd8);
    expect_copy(32'h300, 32'hA00, 32'd4);
    gnt_block = 1;
    send(32'h100, 32'h800, 32'd4);
    send(32'h200, 32'h900, 32'd8);
    burst_valid_i = 1; burst_src_i = 32'h300; burst_dst_i = 32'hA00; burst_num_bytes_i = 32'd4;
    checks++;
    if (burst_ready_o !== 1'b0) begin failures++; $display("FAIL queue_full_ready got=%b exp=0", burst_ready_o); end
    repeat (3) @(negedge clk);
    checks++;
    if (burst_ready_o !== 1'b0) begin failures++; $display("FAIL queue_held_ready got=%b exp=0", burst_ready_o); end
    gnt_block = 0;
    while (!burst_ready_o && k < 100) begin @(negedge clk); k++; end
    checks += 2;
    if (burst_ready_o !== 1'b1) begin failures++; $display("FAIL queue_reopen got=%b exp=1", burst_ready_o); end
    if (completes - c0 != 1) begin failures++; $display("FAIL queue_reopen_after_retire got=%0d exp=1", completes - c0); end
    @(negedge clk);
    burst_valid_i = 0;
    wait_idle("queue");
    checks += 2;
    if (completes - c0 != 3) begin failures++; $display("FAIL queue_complete got=%0d exp=3", completes - c0); end
    if (log_addr.size() != exp_addr.size()) begin failures++; $display("FAIL queue_beats got=%0d exp=%0d", log_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
      checks++;
      if (log_we[i] !== exp_we[i] || log_addr[i] !== exp_addr[i] || (exp_we[i] && log_wdata[i] !== exp_wdata[i])) begin
        failures++; $display("FAIL queue_access%0d got=%b/%h/%h exp=%b/%h/%h", i, log_we[i], log_addr[i], log_wdata[i], exp_we[i], exp_addr[i], exp_wdata[i]);
      end
    end
  endtask

  task automatic test_gnt_delay();
    logic [31:0] a0, w0;
    bit stable;
    int k = 0;
    clear_logs();
    expect_copy(32'h4000, 32'h5000, 32'd4);
    gnt_delay = 5;
    send(32'h4000, 32'h5000, 32'd4);
    while (!mem_req_o && k < 50) begin @(negedge clk); k++; end
    a0 = mem_addr_o;
    stable = mem_req_o && !mem_we_o && a0 == 32'h4000;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (!mem_req_o || mem_we_o || mem_addr_o !== a0) stable = 0;
    end
    checks++;
    if (stable !== 1'b1) begin failures++; $display("FAIL read_stall_stable got=%b exp=1", stable); end
    k = 0;
    while (!(mem_req_o && mem_we_o) && k < 50) begin @(negedge clk); k++; end
    a0 = mem_addr_o;
    w0 = mem_wdata_o;
    stable = mem_req_o && mem_we_o && a0 == 32'h5000;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (!mem_req_o || !mem_we_o || mem_addr_o !== a0 || mem_wdata_o !== w0) stable = 0;
    end
    checks += 2;
    if (stable !== 1'b1) begin failures++; $display("FAIL write_stall_stable got=%b exp=1", stable); end
    if (w0 !== rd_fn(32'h4000)) begin failures++; $display("FAIL stall_wdata got=%h exp=%h", w0, rd_fn(32'h4000)); end
    wait_idle("gnt_delay");
    gnt_delay = 0;
    checks++;
    if (log_addr.size() != exp_addr.size()) begin failures++; $display("FAIL stall_beats got=%0d exp=%0d", log_addr.size(), exp_addr.size()); end
  endtask

  task automatic test_reset_mid();
    int c0, r0, k = 0;
    clear_logs();
    hold_rvalid = 1;
    send(32'h6000, 32'h7000, 32'd16);
    while (!(mem_req_o && !mem_we_o) && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    checks++;
    if (mem_req_o !== 1'b0) begin failures++; $display("FAIL read_wait_req got=%b exp=0", mem_req_o); end
    rst_i = 1;
    @(negedge clk);
    checks += 3;
    if ({burst_ready_o, trans_complete_o, backend_idle_o, error_o} !== 4'b1010) begin failures++; $display("FAIL midreset_status got=%b exp=1010", {burst_ready_o, trans_complete_o, backend_idle_o, error_o}); end
    if ({mem_req_o, mem_we_o} !== 2'b00) begin failures++; $display("FAIL midreset_req_we got=%b exp=00", {mem_req_o, mem_we_o}); end
    if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin failures++; $display("FAIL midreset_addr_wdata got=%h/%h exp=0/0", mem_addr_o, mem_wdata_o); end
    rst_i = 0;
    hold_rvalid = 0;
    c0 = completes;
    r0 = req_cycles;
    repeat (4) @(negedge clk);
    checks += 3;
    if (req_cycles != r0) begin failures++; $display("FAIL stray_rvalid_req got=%0d exp=0", req_cycles - r0); end
    if (completes != c0) begin failures++; $display("FAIL midreset_complete got=%0d exp=0", completes - c0); end
    if (backend_idle_o !== 1'b1) begin failures++; $display("FAIL stray_rvalid_idle got=%b exp=1", backend_idle_o); end
    clear_logs();
    expect_copy(32'h6100, 32'h7100, 32'd4);
    send(32'h6100, 32'h7100, 32'd4);
    wait_idle("after_reset");
    checks += 2;
    if (completes - c0 != 1) begin failures++; $display("FAIL after_reset_complete got=%0d exp=1", completes - c0); end
    if (log_addr.size() != exp_addr.size()) begin failures++; $display("FAIL after_reset_beats got=%0d exp=%0d", log_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
      checks++;
      if (log_we[i] !== exp_we[i] || log_addr[i] !== exp_addr[i] || (exp_we[i] && log_wdata[i] !== exp_wdata[i])) begin
        failures++; $display("FAIL after_reset_access%0d got=%b/%h/%h exp=%b/%h/%h", i, log_we[i], log_addr[i], log_wdata[i], exp_we[i], exp_addr[i], exp_wdata[i]);
      end
    end
  endtask

  initial begin
    rst_i = 1;
    burst_valid_i = 0;
    burst_src_i = 0;
    burst_dst_i = 0;
    burst_num_bytes_i = 0;
    @(negedge clk);
    test_reset();
    test_copy16();
    test_zero();
    test_misaligned();
    test_queue_full();
    test_gnt_delay();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
